// File: rtl/bram_pkg.sv
// Shared types and helpers for the parametrised dual-port block RAM.
// Lane merge works on a fixed maximum word; callers zero-extend and truncate.
package bram_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int LANES          = DATA_WIDTH_DEF / 8;
  localparam int MAX_LANES      = 8;
  localparam int MAX_DW         = MAX_LANES * 8;

  typedef logic [1:0] clr_state_t;

  localparam clr_state_t ST_RESET = 2'd0;
  localparam clr_state_t ST_CLEAR = 2'd1;
  localparam clr_state_t ST_READY = 2'd2;

  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0]    old_w,
    input logic [MAX_DW-1:0]    new_w,
    input logic [MAX_LANES-1:0] be
  );
    logic [MAX_DW-1:0] r_word;
    r_word = old_w;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (be[i]) r_word[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r_word;
  endfunction

endpackage

// File: rtl/bram_dp_param_if.sv
// One RAM access port: request side driven by a bus arbiter, read return
// driven by the RAM.
interface bram_dp_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) ();

  logic                    req;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rvalid;

  modport master (output req, we, be, addr, wdata, input rdata, rvalid);
  modport slave  (input req, we, be, addr, wdata, output rdata, rvalid);

endinterface

// File: rtl/bram_clear_fsm.sv
// Post-reset clear engine: walks every address once, one word per cycle.
//   state    | meaning
//   ST_RESET | rst held or first edge after it; address 0 written on exit
//   ST_CLEAR | writing fill words, counter MSB marks completion
//   ST_READY | memory open to both ports
module bram_clear_fsm
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_busy,
  output logic                  o_clr_we,
  output logic [ADDR_WIDTH-1:0] o_clr_addr
);

  clr_state_t          r_state;
  logic [ADDR_WIDTH:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_RESET: r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
        ST_CLEAR: if (r_cnt[ADDR_WIDTH]) r_state <= ST_READY;
        default:  r_state <= ST_READY;
      endcase
      if (o_clr_we) r_cnt <= r_cnt + (ADDR_WIDTH+1)'(1);
    end
  end

  // The RESET state already writes address 0 so the sweep takes exactly depth cycles.
  assign o_busy     = (r_state == ST_CLEAR) || ((r_state == ST_RESET) && CLEAR_ON_RESET);
  assign o_clr_we   = o_busy && !r_cnt[ADDR_WIDTH];
  assign o_clr_addr = r_cnt[ADDR_WIDTH-1:0];

endmodule

// File: rtl/bram_dp_param.sv
// Single-clock true dual-port RAM with byte enables, read-during-write mode,
// A-priority write collisions, optional output register and a clear engine.
module bram_dp_param
  import bram_pkg::*;
#(
  parameter int                  DATA_WIDTH     = 8,
  parameter int                  ADDR_WIDTH     = 16,
  parameter bit                  OUT_REG        = 1'b0,
  parameter bit                  WRITE_FIRST    = 1'b0,
  parameter bit                  CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] FILL         = '0,
  parameter                      INIT_FILE      = ""
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_busy,
  output logic             o_coll,
  bram_dp_param_if.slave   a_if,
  bram_dp_param_if.slave   b_if
);

  localparam int NLANES = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  logic [NLANES-1:0][7:0] r_mem [DEPTH];

  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;

  logic [1:0]            w_rd_acc;
  logic [1:0]            w_wr_acc;
  logic [ADDR_WIDTH-1:0] w_addr  [2];
  logic [DATA_WIDTH-1:0] w_wdata [2];
  logic [NLANES-1:0]     w_be    [2];
  logic [1:0]            w_rvalid;
  logic [DATA_WIDTH-1:0] w_rdata [2];

  logic                  w_a_we;
  logic [ADDR_WIDTH-1:0] w_a_addr;
  logic [NLANES-1:0]     w_a_be;
  logic [DATA_WIDTH-1:0] w_a_wdata;
  logic                  r_coll;

  bram_clear_fsm #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .o_busy     (o_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign w_addr[0]  = a_if.addr;
  assign w_addr[1]  = b_if.addr;
  assign w_wdata[0] = a_if.wdata;
  assign w_wdata[1] = b_if.wdata;
  assign w_be[0]    = a_if.be;
  assign w_be[1]    = b_if.be;
  assign w_rd_acc   = {b_if.req & ~b_if.we & ~o_busy, a_if.req & ~a_if.we & ~o_busy};
  assign w_wr_acc   = {b_if.req &  b_if.we & ~o_busy, a_if.req &  a_if.we & ~o_busy};

  // Clear engine borrows port A's write path; user requests are blocked meanwhile.
  assign w_a_we    = w_clr_we | w_wr_acc[0];
  assign w_a_addr  = w_clr_we ? w_clr_addr : w_addr[0];
  assign w_a_be    = w_clr_we ? {NLANES{1'b1}} : w_be[0];
  assign w_a_wdata = w_clr_we ? FILL : w_wdata[0];

  // Port A is written last so it owns lanes enabled on both ports.
  always_ff @(posedge i_clk) begin
    for (int l = 0; l < NLANES; l++) begin
      if (w_wr_acc[1] && w_be[1][l]) r_mem[w_addr[1]][l] <= w_wdata[1][l*8 +: 8];
      if (w_a_we && w_a_be[l])       r_mem[w_a_addr][l]  <= w_a_wdata[l*8 +: 8];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_coll <= 1'b0;
    else       r_coll <= w_wr_acc[0] & w_wr_acc[1] & (w_addr[0] == w_addr[1]);
  end

  assign o_coll = r_coll;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  w_ld;
    logic                  r_v1;
    logic                  r_echo;
    logic [DATA_WIDTH-1:0] r_raw;
    logic [DATA_WIDTH-1:0] r_wd;
    logic [NLANES-1:0]     r_be;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_ld = w_rd_acc[p] | (WRITE_FIRST && w_wr_acc[p]);

    // Stage registers only load on a completing access so rdata holds between reads.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_v1   <= 1'b0;
        r_echo <= 1'b0;
        r_raw  <= '0;
        r_wd   <= '0;
        r_be   <= '0;
      end else begin
        r_v1 <= w_ld;
        if (w_ld) begin
          r_raw  <= r_mem[w_addr[p]];
          r_echo <= w_wr_acc[p];
          r_wd   <= w_wdata[p];
          r_be   <= w_be[p];
        end
      end
    end

    assign w_word = r_echo
      ? DATA_WIDTH'(lane_merge(MAX_DW'(r_raw), MAX_DW'(r_wd), MAX_LANES'(r_be)))
      : r_raw;

    if (OUT_REG) begin : g_oreg
      logic                  r_v2;
      logic [DATA_WIDTH-1:0] r_q2;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_v2 <= 1'b0;
          r_q2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_q2 <= w_word;
        end
      end

      assign w_rvalid[p] = r_v2;
      assign w_rdata[p]  = r_q2;
    end else begin : g_direct
      assign w_rvalid[p] = r_v1;
      assign w_rdata[p]  = w_word;
    end
  end

  assign a_if.rdata  = w_rdata[0];
  assign a_if.rvalid = w_rvalid[0];
  assign b_if.rdata  = w_rdata[1];
  assign b_if.rvalid = w_rvalid[1];

endmodule
